// File: rtl/game_pkg.sv
// Shared grid geometry, scan FSM states and a cell accessor for the game blocks.
package game_pkg;

    localparam int GRID_CELLS = 16;
    localparam int CELL_W     = 4;
    localparam int GRID_W     = GRID_CELLS * CELL_W;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scanState_t;

    // Returns the exponent stored in cell idx of a packed grid.
    function automatic logic [CELL_W-1:0] cell_at(input logic [GRID_W-1:0] grid,
                                                  input logic [3:0]        idx);
        return grid[idx*CELL_W +: CELL_W];
    endfunction

endpackage

// File: rtl/game_status_if.sv
// Grid/added-tile inputs from game_logic and the status/highlight outputs to the renderer.
interface game_status_if;
    import game_pkg::*;

    logic [GRID_W-1:0] grid;
    logic [3:0]        added_tile_index;
    logic              status_valid;
    logic [4:0]        empty_count;
    logic [3:0]        max_tile;
    logic              game_over;
    logic              game_won;
    logic              flash_active;
    logic [3:0]        flash_index;

    modport master (
        output grid, added_tile_index,
        input  status_valid, empty_count, max_tile, game_over, game_won,
               flash_active, flash_index
    );

    modport slave (
        input  grid, added_tile_index,
        output status_valid, empty_count, max_tile, game_over, game_won,
               flash_active, flash_index
    );

endinterface

// File: rtl/tile_flash_timer.sv
// Stretches the one-cycle added-tile pulse into a fixed-length highlight window.
module tile_flash_timer #(
    parameter int FLASH_W      = 22,
    parameter int FLASH_CYCLES = 2500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_addedIndex,
    output logic       o_flashActive,
    output logic [3:0] o_flashIndex
);

    logic [FLASH_W-1:0] r_count;
    logic [3:0]         r_index;

    // Index 0 means "no event", so a new event always retargets and restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_index <= 4'd0;
        end else if (i_addedIndex != 4'd0) begin
            r_count <= FLASH_W'(FLASH_CYCLES);
            r_index <= i_addedIndex;
        end else if (r_count != '0) begin
            r_count <= r_count - FLASH_W'(1);
        end
    end

    assign o_flashActive = (r_count != '0);
    assign o_flashIndex  = r_index;

endmodule

// File: rtl/game_status.sv
// Rescans the 4x4 grid one cell per clock after every change and reports
// empty count, max tile, game over and a sticky win flag; also drives the tile highlight.
module game_status
    import game_pkg::*;
#(
    parameter int WIN_TILE     = 11,
    parameter int FLASH_W      = 22,
    parameter int FLASH_CYCLES = 2500000
) (
    input logic          clk,
    input logic          rst_n,
    game_status_if.slave bus
);

    scanState_t        r_state;
    scanState_t        w_nextState;

    logic              r_primed;
    logic [GRID_W-1:0] r_snapshot;
    logic [3:0]        r_idx;
    logic [4:0]        r_emptyAcc;
    logic [3:0]        r_maxAcc;
    logic              r_mergeAcc;

    logic              r_statusValid;
    logic [4:0]        r_emptyCount;
    logic [3:0]        r_maxTile;
    logic              r_gameOver;
    logic              r_gameWon;

    logic              w_change;
    logic              w_lastCell;
    logic              w_load;
    logic              w_scanStep;
    logic              w_commit;
    logic [3:0]        w_cell;
    logic [3:0]        w_right;
    logic [3:0]        w_down;
    logic              w_mergeHere;
    logic [4:0]        w_emptyNext;
    logic [3:0]        w_maxNext;
    logic              w_mergeNext;
    logic              w_flashActive;
    logic [3:0]        w_flashIndex;

    // r_primed forces one scan after reset even when the grid still matches the zeroed snapshot.
    assign w_change    = !r_primed || (bus.grid != r_snapshot);
    assign w_lastCell  = (r_idx == 4'(GRID_CELLS - 1));

    assign w_cell      = cell_at(r_snapshot, r_idx);
    assign w_right     = cell_at(r_snapshot, r_idx + 4'd1);
    assign w_down      = cell_at(r_snapshot, r_idx + 4'd4);
    assign w_mergeHere = (w_cell != 4'd0) &&
                         (((r_idx[1:0] != 2'd3) && (w_cell == w_right)) ||
                          ((r_idx < 4'd12) && (w_cell == w_down)));
    assign w_emptyNext = r_emptyAcc + {4'd0, (w_cell == 4'd0)};
    assign w_maxNext   = (w_cell > r_maxAcc) ? w_cell : r_maxAcc;
    assign w_mergeNext = r_mergeAcc | w_mergeHere;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:    if (w_change) w_nextState = SCAN;
            SCAN:    if (!w_change && w_lastCell) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_load     = w_change;
        w_scanStep = (r_state == SCAN) && !w_change;
        w_commit   = w_scanStep && w_lastCell;
    end

    // Commit folds in cell 15 directly so results land on the same edge that scans it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_primed      <= 1'b0;
            r_snapshot    <= '0;
            r_idx         <= 4'd0;
            r_emptyAcc    <= 5'd0;
            r_maxAcc      <= 4'd0;
            r_mergeAcc    <= 1'b0;
            r_statusValid <= 1'b0;
            r_emptyCount  <= 5'd0;
            r_maxTile     <= 4'd0;
            r_gameOver    <= 1'b0;
            r_gameWon     <= 1'b0;
        end else if (w_load) begin
            r_primed      <= 1'b1;
            r_snapshot    <= bus.grid;
            r_idx         <= 4'd0;
            r_emptyAcc    <= 5'd0;
            r_maxAcc      <= 4'd0;
            r_mergeAcc    <= 1'b0;
            r_statusValid <= 1'b0;
        end else if (w_scanStep) begin
            r_idx      <= r_idx + 4'd1;
            r_emptyAcc <= w_emptyNext;
            r_maxAcc   <= w_maxNext;
            r_mergeAcc <= w_mergeNext;
            if (w_commit) begin
                r_statusValid <= 1'b1;
                r_emptyCount  <= w_emptyNext;
                r_maxTile     <= w_maxNext;
                r_gameOver    <= (w_emptyNext == 5'd0) && !w_mergeNext;
                r_gameWon     <= r_gameWon | (w_maxNext >= 4'(WIN_TILE));
            end
        end
    end

    tile_flash_timer #(
        .FLASH_W      (FLASH_W),
        .FLASH_CYCLES (FLASH_CYCLES)
    ) u_flashTimer (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_addedIndex  (bus.added_tile_index),
        .o_flashActive (w_flashActive),
        .o_flashIndex  (w_flashIndex)
    );

    assign bus.status_valid = r_statusValid;
    assign bus.empty_count  = r_emptyCount;
    assign bus.max_tile     = r_maxTile;
    assign bus.game_over    = r_gameOver;
    assign bus.game_won     = r_gameWon;
    assign bus.flash_active = w_flashActive;
    assign bus.flash_index  = w_flashIndex;

endmodule

// File: tb/tb_game_status.sv
// Randomized and directed bench for game_status against a board-level reference model.
module tb_game_status;
    import game_pkg::*;

    localparam int WIN       = 11;
    localparam int FLASH_LEN = 5;
    localparam int SCAN_LAT  = 17;

    logic clk = 1'b0;
    logic rst_n;

    game_status_if bus();

    game_status #(
        .WIN_TILE     (WIN),
        .FLASH_W      (4),
        .FLASH_CYCLES (FLASH_LEN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int testCount = 0;
    int failCount = 0;

    // Reference model state: board results are recomputed from scratch at commit time.
    bit          primed;
    logic [63:0] lastGrid;
    int          edgesSinceLoad;
    logic        expValid;
    int          expEmpty;
    int          expMax;
    logic        expOver;
    logic        expWon;
    int          flashLeft;
    int          flashIdx;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic void evaluateGrid(input logic [63:0] g, output int empty, output int maxV, output logic over);
        int  board [4][4];
        bit  pair;
        empty = 0;
        maxV  = 0;
        pair  = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                board[r][c] = int'(g[(r*4+c)*4 +: 4]);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (board[r][c] == 0) empty++;
                if (board[r][c] > maxV) maxV = board[r][c];
                if (board[r][c] != 0) begin
                    if (c < 3 && board[r][c+1] == board[r][c]) pair = 1;
                    if (r < 3 && board[r+1][c] == board[r][c]) pair = 1;
                end
            end
        end
        over = (empty == 0) && !pair;
    endfunction

    function automatic logic [63:0] setCell(input logic [63:0] g, input int idx, input int v);
        logic [63:0] res;
        res = g;
        res[idx*4 +: 4] = 4'(v);
        return res;
    endfunction

    function automatic logic [63:0] checkerGrid();
        logic [63:0] g;
        g = '0;
        for (int i = 0; i < 16; i++) g = setCell(g, i, ((i / 4 + i % 4) % 2) + 1);
        return g;
    endfunction

    function automatic logic [63:0] randomGrid();
        logic [63:0] g;
        int mode;
        g    = '0;
        mode = int'($urandom_range(0, 2));
        for (int i = 0; i < 16; i++) begin
            if (mode == 0)      g = setCell(g, i, int'($urandom_range(0, 12)));
            else if (mode == 1) g = setCell(g, i, int'($urandom_range(1, 4)));
            else                g = setCell(g, i, ((i / 4 + i % 4) % 2) * 2 + 1 + int'($urandom_range(0, 1)) * 8);
        end
        return g;
    endfunction

    task automatic resetModel();
        primed         = 0;
        lastGrid       = '0;
        edgesSinceLoad = 0;
        expValid       = 1'b0;
        expEmpty       = 0;
        expMax         = 0;
        expOver        = 1'b0;
        expWon         = 1'b0;
        flashLeft      = 0;
        flashIdx       = 0;
    endtask

    task automatic modelEdge();
        int   e;
        int   m;
        logic o;
        if (!primed || bus.grid != lastGrid) begin
            primed         = 1;
            lastGrid       = bus.grid;
            edgesSinceLoad = 1;
            expValid       = 1'b0;
        end else if (edgesSinceLoad != 0) begin
            edgesSinceLoad++;
            if (edgesSinceLoad == SCAN_LAT) begin
                evaluateGrid(lastGrid, e, m, o);
                expValid       = 1'b1;
                expEmpty       = e;
                expMax         = m;
                expOver        = o;
                expWon         = expWon | (m >= WIN);
                edgesSinceLoad = 0;
            end
        end
        if (bus.added_tile_index != 4'd0) begin
            flashLeft = FLASH_LEN;
            flashIdx  = int'(bus.added_tile_index);
        end else if (flashLeft > 0) begin
            flashLeft--;
        end
    endtask

    task automatic checkAllOutputs();
        checkOutput("status_valid", 64'(bus.status_valid), 64'(expValid));
        checkOutput("empty_count",  64'(bus.empty_count),  64'(expEmpty));
        checkOutput("max_tile",     64'(bus.max_tile),     64'(expMax));
        checkOutput("game_over",    64'(bus.game_over),    64'(expOver));
        checkOutput("game_won",     64'(bus.game_won),     64'(expWon));
        checkOutput("flash_active", 64'(bus.flash_active), 64'(flashLeft != 0));
        if (flashLeft != 0) checkOutput("flash_index", 64'(bus.flash_index), 64'(flashIdx));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"}, 64'(bus.status_valid), 64'd0);
        checkOutput({tag, "_empty"}, 64'(bus.empty_count),  64'd0);
        checkOutput({tag, "_max"},   64'(bus.max_tile),     64'd0);
        checkOutput({tag, "_over"},  64'(bus.game_over),    64'd0);
        checkOutput({tag, "_won"},   64'(bus.game_won),     64'd0);
        checkOutput({tag, "_flash"}, 64'(bus.flash_active), 64'd0);
        checkOutput({tag, "_index"}, 64'(bus.flash_index),  64'd0);
    endtask

    // One clock: drive on the falling edge, advance the model on the rising edge, check just after.
    task automatic applyStimulus(input logic [63:0] g, input logic [3:0] added);
        @(negedge clk);
        bus.grid             = g;
        bus.added_tile_index = added;
        @(posedge clk);
        if (rst_n) modelEdge();
        #1;
        checkAllOutputs();
    endtask

    task automatic holdCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(bus.grid, 4'd0);
    endtask

    // Called just after a rising edge: assert reset between edges, check, release after the next edge.
    task automatic asyncReset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        resetModel();
        checkAllZero(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [63:0] baseGrid;
    logic [63:0] g;

    initial begin
        rst_n                = 1'b0;
        bus.grid             = '0;
        bus.added_tile_index = 4'd0;
        resetModel();
        #2;
        checkAllZero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All-zero board still gets scanned once after reset.
        holdCycles(16);
        checkOutput("zero_not_yet_valid", 64'(bus.status_valid), 64'd0);
        holdCycles(1);
        checkOutput("zero_valid_at_17", 64'(bus.status_valid), 64'd1);
        checkOutput("zero_empty", 64'(bus.empty_count), 64'd16);
        checkOutput("zero_over",  64'(bus.game_over),   64'd0);

        baseGrid = checkerGrid();
        applyStimulus(baseGrid, 4'd0);
        holdCycles(17);
        checkOutput("checker_over",  64'(bus.game_over),   64'd1);
        checkOutput("checker_empty", 64'(bus.empty_count), 64'd0);
        checkOutput("checker_max",   64'(bus.max_tile),    64'd2);

        applyStimulus(setCell(setCell(baseGrid, 5, 3), 9, 3), 4'd0);
        holdCycles(17);
        checkOutput("vertical_pair_over", 64'(bus.game_over), 64'd0);

        applyStimulus(setCell(setCell(baseGrid, 3, 5), 4, 5), 4'd0);
        holdCycles(17);
        checkOutput("rowwrap_pair_over", 64'(bus.game_over), 64'd1);

        // Change lands while the scan is at idx 8.
        g = setCell(baseGrid, 0, 10);
        applyStimulus(g, 4'd0);
        holdCycles(8);
        applyStimulus(setCell(g, 7, 11), 4'd0);
        checkOutput("restart_valid_low", 64'(bus.status_valid), 64'd0);
        holdCycles(15);
        checkOutput("restart_not_early", 64'(bus.status_valid), 64'd0);
        holdCycles(1);
        checkOutput("restart_valid", 64'(bus.status_valid), 64'd1);
        checkOutput("win_max",       64'(bus.max_tile),     64'd11);
        checkOutput("win_flag",      64'(bus.game_won),     64'd1);
        applyStimulus(g, 4'd0);
        holdCycles(17);
        checkOutput("won_sticky",     64'(bus.game_won), 64'd1);
        checkOutput("won_sticky_max", 64'(bus.max_tile), 64'd10);

        // Highlight: pulse 6, retarget to 9 at cycle 3, zero pulses in between.
        applyStimulus(bus.grid, 4'd6);
        checkOutput("flash_idx6", 64'(bus.flash_index), 64'd6);
        applyStimulus(bus.grid, 4'd0);
        applyStimulus(bus.grid, 4'd0);
        applyStimulus(bus.grid, 4'd9);
        checkOutput("flash_idx9", 64'(bus.flash_index), 64'd9);
        holdCycles(4);
        checkOutput("flash_extended", 64'(bus.flash_active), 64'd1);
        holdCycles(1);
        checkOutput("flash_expired", 64'(bus.flash_active), 64'd0);
        holdCycles(2);

        // Reset in the middle of both a scan and a highlight.
        applyStimulus(setCell(baseGrid, 2, 11), 4'd12);
        holdCycles(4);
        asyncReset("midscan_reset");
        holdCycles(18);
        checkOutput("rescan_valid", 64'(bus.status_valid), 64'd1);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 24) == 0) g = randomGrid();
            else                            g = bus.grid;
            applyStimulus(g, ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd0);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/game_status.md
Name: game_status

Overview:
- Sits directly downstream of game_logic and consumes its grid and added_tile_index outputs.
- Scans the 4x4 grid one cell per clock after every grid change and reports:
  - empty-cell count
  - highest tile exponent
  - whether any move is still possible (game over)
  - a sticky win flag
- Also stretches the one-cycle added-tile pulse into a timed highlight for the display renderer.

Parameters:
- WIN_TILE, default 11: tile exponent counted as a win (2^11 = 2048).
- FLASH_W, default 22: width of the highlight down-counter.
- FLASH_CYCLES, default 2500000: highlight duration in clocks; must fit in FLASH_W bits.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, active-low, asynchronous assert
- grid  input  64  tile exponents; cell i = grid[i*4+:4]; row r = cells 4r..4r+3; column = i%4; 0 = empty
- added_tile_index  input  4  one-cycle pulse of the newly placed cell index; 0 = no event
- status_valid  output  1  high when the outputs below reflect the current grid
- empty_count  output  5  number of zero cells, 0..16
- max_tile  output  4  largest exponent on the grid
- game_over  output  1  no empty cell and no equal non-zero neighbours
- game_won  output  1  sticky; set once max_tile >= WIN_TILE
- flash_active  output  1  highlight window running
- flash_index  output  4  cell to highlight

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0, FSM in IDLE, snapshot register 0, scan index 0, flash counter 0.
- Change detection: a 64-bit snapshot register holds the grid being evaluated; change = (grid != snapshot), evaluated every cycle.
- FSM states:
  - IDLE: on change, load snapshot <= grid, idx <= 0, clear accumulators, status_valid <= 0, go to SCAN.
  - SCAN: process cell idx of the snapshot; idx increments each cycle.
  - After idx 15 is processed, commit results and go to IDLE.
  - Change while in SCAN: abort, reload snapshot, idx <= 0, clear accumulators; stay in SCAN with status_valid still 0.
- Per-cell work in SCAN, with v = snapshot cell idx:
  - Empty: if v == 0, empty accumulator += 1.
  - Max: max accumulator = max(acc, v).
  - Merge possible (set flag) if either holds:
    - idx%4 != 3 and v != 0 and v == cell idx+1
    - idx < 12 and v != 0 and v == cell idx+4
- Commit, in the cycle after idx 15 is processed:
  - status_valid <= 1
  - empty_count and max_tile take the accumulators, including the contribution of cell 15
  - game_over <= (empty == 0) && !merge
  - game_won <= game_won | (max >= WIN_TILE)
- Latency: a grid stable from cycle T gives status_valid = 1 at T+17.
- During SCAN, empty_count, max_tile, game_over and game_won hold their last committed values.
- Widths: the empty accumulator is 5 bits and saturates naturally at 16; no wrap is possible.
- All-zero grid (before the game starts): empty_count = 16, game_over = 0.
- game_won is cleared only by reset. game_over is recomputed on every commit.
- Flash:
  - added_tile_index != 0: flash_index <= added_tile_index, counter <= FLASH_CYCLES.
  - Otherwise, counter decrements while non-zero.
  - flash_active = (counter != 0).
  - A new event during an active flash retargets flash_index and restarts the full duration.
  - A cell-0 add produces no flash (index 0 encodes "none").
- Reset mid-scan or mid-flash returns immediately to reset values. After reset release, a non-zero grid triggers a scan on the first edge.

Decomposition:
- Shared package game_pkg:
  - GRID_CELLS = 16, CELL_W = 4
  - FSM state enum (IDLE, SCAN)
  - cell_at(grid, idx) accessor, also usable by game_logic and the renderer
- One sub-module, tile_flash_timer, holding the flash counter and index register. The scan FSM stays in the top.

Test Plan:
- Reset, then grid = 0 held: status_valid = 1 at cycle 17; empty_count = 16, max_tile = 0, game_over = 0, game_won = 0.
- Full grid in a checkerboard of 1/2, no equal neighbours: game_over = 1, empty_count = 0, max_tile = 2.
- Same grid with cells 5 and 9 both = 3 (vertical pair): game_over = 0. Separately, cells 3 and 4 equal (row-wrap pair, not neighbours): game_over = 1.
- Cell 7 set to 11 mid-scan at idx 8:
  - status_valid stays 0 and the scan restarts.
  - Valid 17 cycles after the change, with max_tile = 11 and game_won = 1.
  - game_won stays 1 after the grid returns to max 10.
- added_tile_index pulse 6, with FLASH_CYCLES = 5 in the bench: flash_active high 5 cycles, flash_index = 6. A pulse of 9 at cycle 3 retargets to 9 and extends to 5 more cycles. A pulse of 0 has no effect.
- Assert rst_n low asynchronously mid-scan and mid-flash: all outputs go to 0 without a clock edge; a rescan starts after release.
